or_reduce_pipe: RTL
===================

// Module: or_reduce_pipe
// PURPOSE
//  Parametrised, pipelined N-way bitwise OR with a valid/ready handshake.
//  Each beat ORs NWAY words of WIDTH bits through a registered binary tree.
//  An optional accumulate mode ORs successive beats until a beat marked last.
//  Supplies zero/any flags and a beat count for ALU-style zr tests and sticky-flag collection.
// PARAMETERS
//  WIDTH  16  bits per word
//  NWAY   8   words per beat; legal range 1..64
//  BEATW  8   width of the beat counter
// PORTS
//  clk        in   1            rising-edge clock
//  rst_n      in   1            async active-low reset
//  in_data    in   NWAY*WIDTH   word k at [k*WIDTH +: WIDTH]
//  in_valid   in   1            beat offered
//  in_last    in   1            closes an accumulate packet
//  in_acc     in   1            0 = per-beat result; 1 = accumulate
//  in_ready   out  1            beat accepted when in_valid & in_ready
//  out_data   out  WIDTH        OR result
//  out_any    out  1            |out_data
//  out_zero   out  1            ~|out_data
//  out_beats  out  BEATW        beats folded into out_data; saturating
//  out_valid  out  1            result held until taken
//  out_ready  in   1            downstream accept
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - all pipe valids = 0, acc = 0, acc_cnt = 0
//   - out_valid = 0, out_data = 0, out_any = 0, out_zero = 1, out_beats = 0
//  Tree pipeline:
//   - L = clog2(NWAY) register levels; level i ORs pairs from level i-1
//   - an odd leftover word passes through unchanged
//   - NWAY = 1 gives L = 0 (no tree registers)
//   - in_last and in_acc ride with each beat as sideband
//  Output stage: 1 register.
//   - Per-beat latency = L+1 cycles from accept to out_valid when not stalled
//   - NWAY = 8 gives 4 cycles
//  Stall:
//   - stall = out_valid & ~out_ready
//   - on stall, every stage holds and in_ready = 0
//   - otherwise in_ready = 1
//   - bubbles are not compressed; global stall keeps the design simple
//  Output stage on a tree-output beat r with sideband (last, acc), when not stalled:
//   - acc=0: out_data=r, out_beats=1, out_valid=1; accumulator untouched
//   - acc=1, last=0: acc|=r, acc_cnt=sat(acc_cnt+1); out_valid drops to 0 if it was just taken
//   - acc=1, last=1: out_data=acc|r, out_beats=sat(acc_cnt+1), out_valid=1; acc and acc_cnt clear the same edge
//  No tree-output beat and out_ready = 1: out_valid -> 0.
//  Flags are registered together with out_data, so they are always consistent with it.
//  Boundary cases:
//   - acc_cnt saturates at 2^BEATW-1 and never wraps
//   - a per-beat (acc=0) beat inside an open packet passes through; packet stays open
//   - in_valid with in_ready = 0: beat not taken; source must hold data stable
//   - reset mid-packet discards the tree contents and the accumulator
//   - NWAY = 1 with acc = 0 is a registered pass-through with flags
// STRUCTURE
//  Shared package/header:
//   - CLOG2 function
//   - MODE_BEAT = 1'b0, MODE_ACC = 1'b1
//  One sub-module: or_tree_level
//   - one registered level: IN_WORDS -> ceil(IN_WORDS/2) words, with valid/sideband and stall hold
//   - instantiated by a generate loop over L
//  The accumulator/output stage stays in the top module.
// TESTING
//  1. WIDTH=16 NWAY=8: word3=0x0100, word6=0x0001, others 0, acc=0
//     -> out_data=0x0101, any=1, zero=0, beats=1, exactly 4 cycles after accept
//  2. All-zero beat -> out_data=0, zero=1, any=0. Reset -> zero=1, out_valid=0
//  3. acc=1, beats 0x0001, 0x0010, 0x8000 (last on third)
//     -> a single out_valid with 0x8011, beats=3; next packet starts from 0
//  4. Hold out_ready=0 for 5 cycles while streaming 6 beats
//     -> in_ready=0 during the stall, no beat lost or duplicated, order preserved
//  5. BEATW=2, 5-beat packet -> out_beats=3 (saturated)
//     acc=0 beat mid-packet -> emitted alone; packet total is unaffected
//  6. Assert rst_n low mid-packet with the pipe full
//     -> outputs go to reset values immediately; a following packet's result excludes pre-reset beats

Source files
------------

// File: rtl/or_reduce_pipe_pkg.sv
// Shared definitions for the pipelined OR-reduction block.
//   MODE_BEAT / MODE_ACC : in_acc encodings (per-beat result vs accumulate)
//   side_t               : sideband carried alongside each beat through the tree
//   clog2 / words_at / out_off : elaboration-time helpers for sizing the tree
package or_reduce_pipe_pkg;

    localparam logic MODE_BEAT = 1'b0;
    localparam logic MODE_ACC  = 1'b1;

    typedef struct packed {
        logic last;
        logic acc;
    } side_t;

    // Ceiling log2; clog2(1) = 0 so a single-word beat has no tree levels.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((33'd1 << r) < 33'(n)) r = r + 1;
        end
        return r;
    endfunction

    // Number of words left after lvl pairwise-OR levels.
    function automatic int unsigned words_at(input int unsigned nway, input int unsigned lvl);
        int unsigned w;
        w = nway;
        for (int unsigned k = 0; k < lvl; k++) w = (w + 1) / 2;
        return w;
    endfunction

    // Word offset of level lvl's output inside the flattened level bus.
    function automatic int unsigned out_off(input int unsigned nway, input int unsigned lvl);
        int unsigned s;
        s = 0;
        for (int unsigned k = 1; k <= lvl; k++) s = s + words_at(nway, k);
        return s;
    endfunction

endpackage

// File: rtl/or_reduce_pipe_tree_level.sv
// One registered OR-tree level: IN_WORDS words -> ceil(IN_WORDS/2) words.
// Pairs (2j, 2j+1) are ORed; an odd trailing word passes through unchanged.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   stall_i           hold every register when set
//   data_i/valid_i/side_i   beat from the previous level
//   data_o/valid_o/side_o   registered beat for the next level
module or_tree_level
    import or_reduce_pipe_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned IN_WORDS = 8
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   stall_i,
    input  logic [IN_WORDS*WIDTH-1:0]              data_i,
    input  logic                                   valid_i,
    input  side_t                                  side_i,
    output logic [((IN_WORDS+1)/2)*WIDTH-1:0]      data_o,
    output logic                                   valid_o,
    output side_t                                  side_o
);

    localparam int unsigned OUT_WORDS = (IN_WORDS + 1) / 2;

    logic [OUT_WORDS*WIDTH-1:0] pair_or;
    logic [OUT_WORDS*WIDTH-1:0] data_q, data_d;
    logic                       valid_q, valid_d;
    side_t                      side_q, side_d;

    // Pairwise OR; the unpaired last word of an odd count is forwarded as-is.
    for (genvar j = 0; j < OUT_WORDS; j++) begin : g_pair
        if (2 * j + 1 < IN_WORDS) begin : g_two
            assign pair_or[j*WIDTH +: WIDTH] = data_i[2*j*WIDTH +: WIDTH]
                                             | data_i[(2*j+1)*WIDTH +: WIDTH];
        end else begin : g_one
            assign pair_or[j*WIDTH +: WIDTH] = data_i[2*j*WIDTH +: WIDTH];
        end
    end

    // Next state: capture when the pipe moves, hold on stall.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        side_d  = side_q;
        if (!stall_i) begin
            data_d  = pair_or;
            valid_d = valid_i;
            side_d  = side_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            side_q  <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            side_q  <= side_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign side_o  = side_q;

endmodule

// File: rtl/or_reduce_pipe.sv
// Pipelined NWAY-word bitwise OR with valid/ready handshake and optional
// accumulation of successive beats up to a beat marked last.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_data/in_valid/in_last/in_acc/in_ready   input beat handshake
//   out_data/out_any/out_zero/out_beats        registered result and flags
//   out_valid/out_ready                        output handshake
module or_reduce_pipe
    import or_reduce_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NWAY  = 8,
    parameter int unsigned BEATW = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NWAY*WIDTH-1:0]   in_data,
    input  logic                    in_valid,
    input  logic                    in_last,
    input  logic                    in_acc,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_any,
    output logic                    out_zero,
    output logic [BEATW-1:0]        out_beats,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int unsigned     L       = clog2(NWAY);
    localparam logic [BEATW-1:0] CNT_MAX = '1;

    logic             stall_c;
    logic             in_take;
    side_t            in_side;
    logic [WIDTH-1:0] tree_data;
    logic             tree_valid;
    side_t            tree_side;

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_any_q, out_any_d;
    logic             out_zero_q, out_zero_d;
    logic [BEATW-1:0] out_beats_q, out_beats_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [BEATW-1:0] acc_cnt_q, acc_cnt_d;
    logic [BEATW-1:0] cnt_inc;

    // Global stall: a held, untaken result freezes the whole pipe.
    assign stall_c  = out_valid_q & ~out_ready;
    assign in_ready = ~stall_c;
    assign in_take  = in_valid & in_ready;
    assign in_side  = '{last: in_last, acc: in_acc};

    // Reduction tree; every level's output is packed into one flat bus.
    if (L == 0) begin : g_no_tree
        assign tree_data  = in_data;
        assign tree_valid = in_take;
        assign tree_side  = in_side;
    end else begin : g_tree
        localparam int unsigned TOTW = out_off(NWAY, L);

        logic [TOTW*WIDTH-1:0] lvl_data;
        logic [L-1:0]          lvl_valid;
        side_t [L-1:0]         lvl_side;

        for (genvar i = 0; i < L; i++) begin : g_lvl
            localparam int unsigned WI = words_at(NWAY, i);
            localparam int unsigned WO = words_at(NWAY, i + 1);
            localparam int unsigned OO = out_off(NWAY, i);

            if (i == 0) begin : g_first
                or_tree_level #(.WIDTH(WIDTH), .IN_WORDS(WI)) u_lvl (
                    .clk     (clk),
                    .rst_n   (rst_n),
                    .stall_i (stall_c),
                    .data_i  (in_data),
                    .valid_i (in_take),
                    .side_i  (in_side),
                    .data_o  (lvl_data[OO*WIDTH +: WO*WIDTH]),
                    .valid_o (lvl_valid[i]),
                    .side_o  (lvl_side[i])
                );
            end else begin : g_next
                localparam int unsigned OI = out_off(NWAY, i - 1);
                or_tree_level #(.WIDTH(WIDTH), .IN_WORDS(WI)) u_lvl (
                    .clk     (clk),
                    .rst_n   (rst_n),
                    .stall_i (stall_c),
                    .data_i  (lvl_data[OI*WIDTH +: WI*WIDTH]),
                    .valid_i (lvl_valid[i-1]),
                    .side_i  (lvl_side[i-1]),
                    .data_o  (lvl_data[OO*WIDTH +: WO*WIDTH]),
                    .valid_o (lvl_valid[i]),
                    .side_o  (lvl_side[i])
                );
            end
        end

        assign tree_data  = lvl_data[out_off(NWAY, L-1)*WIDTH +: WIDTH];
        assign tree_valid = lvl_valid[L-1];
        assign tree_side  = lvl_side[L-1];
    end

    // Output / accumulator stage; flags derive from the next out_data.
    always_comb begin
        out_data_d  = out_data_q;
        out_beats_d = out_beats_q;
        out_valid_d = out_valid_q;
        acc_d       = acc_q;
        acc_cnt_d   = acc_cnt_q;
        cnt_inc     = (acc_cnt_q == CNT_MAX) ? CNT_MAX : acc_cnt_q + BEATW'(1);

        if (!stall_c) begin
            out_valid_d = 1'b0;
            if (tree_valid) begin
                unique case (tree_side.acc)
                    MODE_BEAT: begin
                        out_data_d  = tree_data;
                        out_beats_d = BEATW'(1);
                        out_valid_d = 1'b1;
                    end
                    MODE_ACC: begin
                        if (tree_side.last) begin
                            out_data_d  = acc_q | tree_data;
                            out_beats_d = cnt_inc;
                            out_valid_d = 1'b1;
                            acc_d       = '0;
                            acc_cnt_d   = '0;
                        end else begin
                            acc_d       = acc_q | tree_data;
                            acc_cnt_d   = cnt_inc;
                        end
                    end
                endcase
            end
        end

        out_any_d  = |out_data_d;
        out_zero_d = ~|out_data_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_any_q   <= 1'b0;
            out_zero_q  <= 1'b1;
            out_beats_q <= '0;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            acc_cnt_q   <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_any_q   <= out_any_d;
            out_zero_q  <= out_zero_d;
            out_beats_q <= out_beats_d;
            out_valid_q <= out_valid_d;
            acc_q       <= acc_d;
            acc_cnt_q   <= acc_cnt_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_any   = out_any_q;
    assign out_zero  = out_zero_q;
    assign out_beats = out_beats_q;
    assign out_valid = out_valid_q;

endmodule
